// File: rtl/program_counter.sv
// program_counter: picoMIPS fetch address generator; define PC_HALT_DETECT_EN to enable the branch-to-self HALT state
module program_counter #(
  parameter int P_SIZE = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              branchAbsolute,
  input  logic              branchRelative,
  input  logic [P_SIZE-1:0] target,
  input  logic [P_SIZE-1:0] offset,
  input  logic              waitInst,
  input  logic              ready,
  output logic [P_SIZE-1:0] address,
  output logic              waiting,
  output logic              halted
);
  typedef enum logic [1:0] {RUN, ARM, HOLD, HALT} state_t;
  state_t state, state_n;
  logic [P_SIZE-1:0] addr_n;
  logic [1:0] sync;
  logic ready_s, halt_hit;
  assign ready_s = sync[1];
  assign waiting = state == ARM || state == HOLD;
`ifdef PC_HALT_DETECT_EN
  assign halt_hit = (branchRelative && offset == '0) || (branchAbsolute && target == address);
  assign halted = state == HALT;
`else
  assign halt_hit = 1'b0;
  assign halted = 1'b0;
`endif
  // two-flop synchroniser for the asynchronous ready input, free-running regardless of enable
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[0], ready};
  // PC and FSM state advance only when enabled
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      address <= '0;
    end else if (enable) begin
      state <= state_n;
      address <= addr_n;
    end
  // next address selection; ARM waits for release, HOLD waits for the next press
  always_comb begin
    state_n = state;
    addr_n = address;
    case (state)
      RUN:
        if (waitInst) state_n = ARM;
        else if (halt_hit) state_n = HALT;
        else addr_n = branchAbsolute ? target : branchRelative ? address + offset : address + P_SIZE'(1);
      ARM:
        if (!ready_s) state_n = HOLD;
      HOLD:
        if (ready_s) begin
          state_n = RUN;
          addr_n = address + P_SIZE'(1);
        end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: randomized scoreboard bench for program_counter against a spec-level model
module tb_program_counter;
  localparam int P = 6;
  localparam int DEPTH = 1 << P;
`ifdef PC_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  logic clk = 0, reset = 1, enable = 0, branchAbsolute = 0, branchRelative = 0, waitInst = 0, ready = 0;
  logic [P-1:0] target = '0, offset = '0, address;
  logic waiting, halted;
  int n_vec = 0, n_err = 0;
  typedef struct {int addr; bit wt; bit hl;} exp_t;
  exp_t sb[$];
  int m_addr, m_mode;
  bit hist[$];

  program_counter #(.P_SIZE(P)) dut (
    .clk(clk), .reset(reset), .enable(enable), .branchAbsolute(branchAbsolute),
    .branchRelative(branchRelative), .target(target), .offset(offset),
    .waitInst(waitInst), .ready(ready), .address(address), .waiting(waiting), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 0;
    m_mode = 0;
    hist = '{0, 0};
  endtask

  // m_mode: 0 running, 1 waiting for release, 2 waiting for press, 3 halted
  task automatic model_step();
    bit rs;
    exp_t e;
    rs = hist[1];
    hist.push_front(ready);
    if (hist.size() > 4) void'(hist.pop_back());
    if (enable) begin
      if (m_mode == 0) begin
        if (waitInst) m_mode = 1;
        else if (HALT_EN && ((branchRelative && offset == 0) || (branchAbsolute && int'(target) == m_addr))) m_mode = 3;
        else if (branchAbsolute) m_addr = int'(target);
        else if (branchRelative) m_addr = (m_addr + int'(offset)) % DEPTH;
        else m_addr = (m_addr + 1) % DEPTH;
      end else if (m_mode == 1) begin
        if (!rs) m_mode = 2;
      end else if (m_mode == 2) begin
        if (rs) begin
          m_mode = 0;
          m_addr = (m_addr + 1) % DEPTH;
        end
      end
    end
    e.addr = m_addr;
    e.wt = m_mode == 1 || m_mode == 2;
    e.hl = m_mode == 3;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit en, input bit ba, input bit br, input int tgt, input int off, input bit wi, input bit rd);
    enable = en;
    branchAbsolute = ba;
    branchRelative = br;
    target = P'(tgt);
    offset = P'(off);
    waitInst = wi;
    ready = rd;
    model_step();
    @(negedge clk);
  endtask

  task automatic goto(input int a);
    if (m_addr != a) cyc(1, 1, 0, a, 1, 0, ready);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("address", int'(address), e.addr);
      check("waiting", int'(waiting), int'(e.wt));
      check("halted", int'(halted), int'(e.hl));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_address", int'(address), 0);
    check("reset_waiting", int'(waiting), 0);
    check("reset_halted", int'(halted), 0);
    reset = 0;
    repeat (DEPTH + 2) cyc(1, 0, 0, 0, 0, 0, 0);
    goto(5);
    cyc(1, 1, 1, 'h20, 3, 0, 0);
    goto(2);
    cyc(1, 0, 1, 0, 'h3E, 0, 0);
    goto(62);
    cyc(1, 0, 1, 0, 4, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
    goto(9);
    cyc(1, 0, 0, 0, 0, 1, 1);
    repeat (4) cyc(1, 1, 1, $urandom, $urandom, 1, 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0, 0, 1);
    goto(7);
    repeat (4) cyc(0, 1, 1, $urandom, $urandom, $urandom, $urandom);
    cyc(1, 0, 0, 0, 0, 0, 0);
    goto(20);
    cyc(1, 0, 0, 0, 0, 1, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    check("async_reset_address", int'(address), 0);
    check("async_reset_waiting", int'(waiting), 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 400; i++) begin
      int tgt, off;
      bit ba, br, wi;
      tgt = $urandom_range(0, DEPTH - 1);
      off = $urandom_range(0, DEPTH - 1);
      ba = $urandom_range(0, 3) == 0;
      br = $urandom_range(0, 3) == 0;
      wi = $urandom_range(0, 9) == 0;
      if (HALT_EN && off == 0) off = 1;
      if (HALT_EN && tgt == m_addr) tgt = (m_addr + 1) % DEPTH;
      cyc($urandom_range(0, 7) != 0, ba, br, tgt, off, wi, $urandom_range(0, 3) != 0);
    end
    repeat (8) cyc(1, 0, 0, 0, 0, 0, 1);
    goto(12);
    repeat (3) cyc(1, 0, 1, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/program_counter.md
# program_counter

- Fetch-address generator for the picoMIPS core; sits directly upstream of `programMemory` and drives its `address` input.
- Each cycle it selects the next program address: sequential increment, absolute jump, PC-relative branch, or hold.
- Holds on a WAIT instruction until an external `ready` handshake completes.
- `programMemory` is combinational, so the addressed instruction is valid in the same cycle the address is presented.

## Interface

Parameters:
- `P_SIZE`, 6: program address width; memory depth is 2^P_SIZE words.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  global advance enable; low freezes the PC and FSM (synchroniser still runs).
- `branchAbsolute`  in  1  load `target` as the next address.
- `branchRelative`  in  1  next address = address + `offset`.
- `target`  in  P_SIZE  absolute jump destination.
- `offset`  in  P_SIZE  two's-complement relative displacement.
- `waitInst`  in  1  decoder flags the current instruction as WAIT.
- `ready`  in  1  asynchronous external continue input (switch/button).
- `address`  out  P_SIZE  registered current PC, drives `programMemory.address`.
- `waiting`  out  1  high while the FSM is in ARM or HOLD.
- `halted`  out  1  high in HALT state (only when `PC_HALT_DETECT_EN` is defined).

## Operation

- `ready` passes through a 2-flop synchroniser, giving `readyS`; both flops reset to 0.
- FSM states: RUN, ARM, HOLD, HALT.
- **RUN**, with `enable`=1, applies the first matching rule in this priority order:
  1. `waitInst`=1: hold PC, go to ARM.
  2. `branchAbsolute`=1: PC ← `target`.
  3. `branchRelative`=1: PC ← (PC + sign-extended `offset`) mod 2^P_SIZE.
  4. Otherwise: PC ← (PC + 1) mod 2^P_SIZE.
- **ARM**: PC held; go to HOLD when `readyS`=0. This forces a release before each press, so one press passes exactly one WAIT.
- **HOLD**: PC held; when `readyS`=1, PC ← PC + 1 and return to RUN.
- **HALT**: PC held permanently; exits only on `reset`.
- Branch inputs are ignored in ARM, HOLD and HALT.
- `branchAbsolute` and `branchRelative` both high: absolute wins.
- Address arithmetic is P_SIZE bits, unsigned wrap:
  - 63 + 1 → 0.
  - 2 + offset 6'h3E (−2) → 0.
  - 0 + 6'h3F (−1) → 63.
- `enable`=0 in any state: PC and FSM state hold.
- `reset` at any time, including mid-WAIT:
  - `address` = 0, state = RUN, `waiting` = 0, `halted` = 0, synchroniser cleared.
  - Takes effect immediately, with no clock edge required.

## Timing

- `address` changes only on a rising `clk` edge, or asynchronously on `reset`.
- The instruction at the new address is valid in the same cycle.
- Decode outputs (`waitInst`, branch inputs) are sampled at the end of that cycle.
- Branch penalty: 0 cycles. The cycle after a branch instruction presents the target address.
- A `ready` rising edge reaches `readyS` after 2 edges. The PC advances on the 3rd edge after `ready` goes high, provided the FSM is in HOLD.
- `waiting` is registered: it rises on the edge entering ARM and falls on the edge leaving HOLD.

## Configuration

- `PC_HALT_DETECT_EN` defined:
  - In RUN with `enable`=1, either of these moves the FSM to HALT on the next edge with PC unchanged:
    - `branchRelative`=1 and `offset`=0;
    - `branchAbsolute`=1 and `target`=`address`.
  - `halted` goes high on that same edge.
- `PC_HALT_DETECT_EN` undefined:
  - No HALT state; `halted` is tied to 0.
  - Branch-to-self re-loads the same address every cycle, i.e. a normal infinite loop.

## Test plan

- **Reset and increment:** hold `reset` then release; no branches, `enable`=1 → `address` reads 0, 1, 2 … 63, 0 on consecutive edges.
- **Branch priority:** at `address`=5, assert `branchAbsolute` with `target`=0x20 together with `branchRelative` with `offset`=3 → next `address`=0x20.
- **Relative wrap:** at `address`=2 with `offset`=6'h3E → 0. At `address`=62 with `offset`=4 → 2.
- **WAIT handshake:** `waitInst` at `address`=9 with `ready`=1 held → stays 9 in ARM. Drop `ready` → HOLD. Raise `ready` → `address`=10 exactly 3 edges later, `waiting` 1→0.
- **Enable and reset mid-operation:** `enable`=0 for 4 cycles at `address`=7 → stays 7. Assert `reset` asynchronously mid-cycle in HOLD → `address`=0 and `waiting`=0 before the next edge.
- **Halt detection:** relative branch with `offset`=0 at `address`=12 → with the macro, `halted`=1 and `address` stays 12 even after the branch inputs drop. Without the macro, `halted`=0 and `address` stays 12 only while the branch is held, incrementing once it drops.
